// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: stage indices, per-register command vectors, controller state.
package pipe_pkg;
   localparam int NSTAGE = 5;
   localparam int PC     = 0;
   localparam int IFID   = 1;
   localparam int IDEX   = 2;
   localparam int EXMEM  = 3;
   localparam int MEMWB  = 4;

   typedef logic [NSTAGE-1:0] stage_vec_t;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DIV      = 2'd1,
      EXC_WAIT = 2'd2
   } ctrl_state_t;

   // Hold every register from the PC up to and including stage s.
   function automatic stage_vec_t hold_thru(input int s);
      hold_thru = stage_vec_t'((32'd1 << (s + 1)) - 32'd1);
   endfunction

   function automatic stage_vec_t bubble_at(input int s);
      bubble_at = stage_vec_t'(32'd1 << s);
   endfunction
endpackage

// File: rtl/pipeline_ctrl_div_counter.sv
// Divide occupancy counter: loads on start, counts down while active, freezes on D-cache wait.
// busy_o holds EX while counting; done_o marks the cycle the quotient is valid.
module div_counter #(
   parameter int DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic freeze_i,
   input  logic abort_i,
   input  logic active_i,
   output logic busy_o,
   output logic done_o
);
   localparam int CW = $clog2(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          cnt_zero;

   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (abort_i) begin
         cnt_d = '0;
      end else if (start_i) begin
         cnt_d = CNT_LOAD;
      end else if (active_i && !cnt_zero && !freeze_i) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = active_i & ~cnt_zero;
   assign done_o = active_i & cnt_zero & ~abort_i;
endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush generator for the 5-stage pipeline: prioritises exceptions, D-cache wait,
// divider occupancy, load-use and I-cache wait into per-register hold/bubble commands.
module pipeline_ctrl
   import pipe_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       imem_wait,
   input  logic       dmem_wait,
   input  logic       load_use,
   input  logic       div_start,
   input  logic       exc_valid,
   output stage_vec_t stall,
   output stage_vec_t flush,
   output logic       div_busy,
   output logic       div_done,
   output logic       exc_redirect
);
   ctrl_state_t state_q, state_d;
   logic        in_run, in_div, in_exc;
   logic        exc_take, div_go, div_count, div_fin;
   stage_vec_t  stall_c, flush_c;
   logic        redirect_c;

   // Any unknown encoding behaves as RUN.
   always_comb begin
      in_run = 1'b0;
      in_div = 1'b0;
      in_exc = 1'b0;
      case (state_q)
         DIV:      in_div = 1'b1;
         EXC_WAIT: in_exc = 1'b1;
         default:  in_run = 1'b1;
      endcase
   end

   assign exc_take = exc_valid | in_exc;
   assign div_go   = in_run & div_start & ~exc_take;

   div_counter #(
      .DIV_CYCLES(DIV_CYCLES)
   ) u_div_counter (
      .clk      (clk),
      .rst      (rst),
      .start_i  (div_go),
      .freeze_i (dmem_wait),
      .abort_i  (exc_take),
      .active_i (in_div),
      .busy_o   (div_count),
      .done_o   (div_fin)
   );

   always_comb begin
      state_d    = RUN;
      stall_c    = '0;
      flush_c    = '0;
      redirect_c = 1'b0;
      if (exc_take) begin
         flush_c    = ~bubble_at(PC);
         redirect_c = ~imem_wait;
         state_d    = imem_wait ? EXC_WAIT : RUN;
      end else begin
         if (dmem_wait) begin
            stall_c = hold_thru(EXMEM);
            flush_c = bubble_at(MEMWB);
         end else if (div_count || (in_run && div_start)) begin
            stall_c = hold_thru(IDEX);
            flush_c = bubble_at(EXMEM);
         end else if (load_use) begin
            stall_c = hold_thru(IFID);
            flush_c = bubble_at(IDEX);
         end else if (imem_wait) begin
            stall_c = hold_thru(PC);
            flush_c = bubble_at(IFID);
         end
         if (div_go || (in_div && !div_fin)) begin
            state_d = DIV;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Reset overrides the decoded commands combinationally so the datapath empties immediately.
   assign stall        = rst ? stall_c : '0;
   assign flush        = rst ? flush_c : '1;
   assign exc_redirect = rst & redirect_c;
   assign div_busy     = in_div;
   assign div_done     = div_fin;
endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
   localparam int DIVC = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       imem_wait = 1'b0, dmem_wait = 1'b0, load_use = 1'b0, div_start = 1'b0, exc_valid = 1'b0;
   logic [4:0] stall, flush;
   logic       div_busy, div_done, exc_redirect;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.DIV_CYCLES(DIVC)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_wait    (imem_wait),
      .dmem_wait    (dmem_wait),
      .load_use     (load_use),
      .div_start    (div_start),
      .exc_valid    (exc_valid),
      .stall        (stall),
      .flush        (flush),
      .div_busy     (div_busy),
      .div_done     (div_done),
      .exc_redirect (exc_redirect)
   );

   typedef struct {
      logic [5:0]  in;   // {rst, imem_wait, dmem_wait, load_use, div_start, exc_valid}
      logic [12:0] exp;  // {stall, flush, div_busy, div_done, exc_redirect}
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [5:0] in, input logic [4:0] s, input logic [4:0] f,
                               input logic [2:0] bdr);
      vec_t v;
      v.in  = in;
      v.exp = {s, f, bdr};
      return v;
   endfunction

   task automatic set_in(input logic [5:0] in);
      {rst, imem_wait, dmem_wait, load_use, div_start, exc_valid} = in;
   endtask

   function automatic logic [12:0] outs();
      return {stall, flush, div_busy, div_done, exc_redirect};
   endfunction

   task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b required=%b", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d required=%0d", name, got, exp);
      end
   endtask

   // Reference model: divide in flight with remaining countdown, plus a pending-redirect flag.
   bit m_div;
   int m_left;
   bit m_exc;

   function automatic logic [12:0] model_out();
      logic [4:0] s, f;
      bit exc, done, r;
      if (!rst) return {5'b00000, 5'b11111, 3'b000};
      exc  = exc_valid || m_exc;
      done = m_div && (m_left == 0) && !exc;
      s = 5'b00000; f = 5'b00000; r = 1'b0;
      if (exc) begin
         f = 5'b11110; r = !imem_wait;
      end else if (dmem_wait) begin
         s = 5'b01111; f = 5'b10000;
      end else if ((m_div && m_left > 0) || (!m_div && div_start)) begin
         s = 5'b00111; f = 5'b01000;
      end else if (load_use) begin
         s = 5'b00011; f = 5'b00100;
      end else if (imem_wait) begin
         s = 5'b00001; f = 5'b00010;
      end
      return {s, f, m_div, done, r};
   endfunction

   task automatic model_step();
      if (!rst) begin
         m_div = 0; m_left = 0; m_exc = 0;
      end else if (exc_valid || m_exc) begin
         m_div = 0; m_left = 0; m_exc = imem_wait;
      end else if (!m_div && div_start) begin
         m_div = 1; m_left = DIVC - 1;
      end else if (m_div) begin
         if (m_left == 0) m_div = 0;
         else if (!dmem_wait) m_left = m_left - 1;
      end
   endtask

   initial begin
      int done_k;

      // Reset, divide timing, priority combinations, exception during divide, simultaneous events.
      tbl.push_back(mk(6'b0_11111, 5'b00000, 5'b11111, 3'b000));
      tbl.push_back(mk(6'b0_01010, 5'b00000, 5'b11111, 3'b000));
      tbl.push_back(mk(6'b0_10101, 5'b00000, 5'b11111, 3'b000));
      tbl.push_back(mk(6'b1_00000, 5'b00000, 5'b00000, 3'b000));
      tbl.push_back(mk(6'b1_00010, 5'b00111, 5'b01000, 3'b000));
      tbl.push_back(mk(6'b1_00000, 5'b00111, 5'b01000, 3'b100));
      tbl.push_back(mk(6'b1_00000, 5'b00111, 5'b01000, 3'b100));
      tbl.push_back(mk(6'b1_00000, 5'b00111, 5'b01000, 3'b100));
      tbl.push_back(mk(6'b1_00000, 5'b00000, 5'b00000, 3'b110));
      tbl.push_back(mk(6'b1_00000, 5'b00000, 5'b00000, 3'b000));
      tbl.push_back(mk(6'b1_10100, 5'b00011, 5'b00100, 3'b000));
      tbl.push_back(mk(6'b1_10000, 5'b00001, 5'b00010, 3'b000));
      tbl.push_back(mk(6'b1_01000, 5'b01111, 5'b10000, 3'b000));
      tbl.push_back(mk(6'b1_00001, 5'b00000, 5'b11110, 3'b001));
      tbl.push_back(mk(6'b1_00010, 5'b00111, 5'b01000, 3'b000));
      tbl.push_back(mk(6'b1_00000, 5'b00111, 5'b01000, 3'b100));
      tbl.push_back(mk(6'b1_10001, 5'b00000, 5'b11110, 3'b100));
      tbl.push_back(mk(6'b1_10000, 5'b00000, 5'b11110, 3'b000));
      tbl.push_back(mk(6'b1_00000, 5'b00000, 5'b11110, 3'b001));
      tbl.push_back(mk(6'b1_00000, 5'b00000, 5'b00000, 3'b000));
      tbl.push_back(mk(6'b1_00011, 5'b00000, 5'b11110, 3'b001));
      tbl.push_back(mk(6'b1_00000, 5'b00000, 5'b00000, 3'b000));
      tbl.push_back(mk(6'b1_00110, 5'b00111, 5'b01000, 3'b000));
      tbl.push_back(mk(6'b1_00100, 5'b00111, 5'b01000, 3'b100));
      tbl.push_back(mk(6'b1_00000, 5'b00111, 5'b01000, 3'b100));
      tbl.push_back(mk(6'b1_00000, 5'b00111, 5'b01000, 3'b100));
      tbl.push_back(mk(6'b1_01000, 5'b01111, 5'b10000, 3'b110));
      tbl.push_back(mk(6'b1_00000, 5'b00000, 5'b00000, 3'b000));

      foreach (tbl[i]) begin
         @(negedge clk);
         set_in(tbl[i].in);
         #1;
         check($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end

      // D-cache wait during a divide freezes the countdown for exactly its duration.
      @(negedge clk);
      set_in(6'b1_00010);
      #1;
      check("div_freeze_start", outs(), {5'b00111, 5'b01000, 3'b000});
      done_k = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         set_in({1'b1, 1'b0, (k >= 2 && k <= 4), 3'b000});
         #1;
         if (k >= 2 && k <= 4) check($sformatf("div_freeze_hold%0d", k), outs(), {5'b01111, 5'b10000, 3'b100});
         if (div_done) begin
            done_k = k;
            break;
         end
      end
      check_int("div_freeze_done_cycle", done_k, DIVC + 3);
      @(negedge clk);
      set_in(6'b1_00000);
      #1;
      check("div_freeze_idle", outs(), 13'd0);

      // Asynchronous reset in the middle of an EXC_WAIT cycle.
      @(negedge clk);
      set_in(6'b1_10001);
      @(negedge clk);
      set_in(6'b1_10000);
      #1;
      check("exc_wait_flush", outs(), {5'b00000, 5'b11110, 3'b000});
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_mid_cycle", outs(), {5'b00000, 5'b11111, 3'b000});
      @(negedge clk);
      set_in(6'b1_00000);
      #1;
      check("post_reset_run", outs(), 13'd0);

      // Randomised run against the reference model.
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      model_step();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 99) != 0);
         imem_wait = ($urandom_range(0, 2) == 0);
         dmem_wait = ($urandom_range(0, 3) == 0);
         load_use  = ($urandom_range(0, 2) == 0);
         div_start = ($urandom_range(0, 5) == 0);
         exc_valid = ($urandom_range(0, 15) == 0);
         #1;
         check($sformatf("rand%0d", i), outs(), model_out());
         @(posedge clk);
         model_step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
